// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS32 main control FSM sequencing fetch/decode/execute/memory/writeback,
// stalling in FETCH, MEMRD and MEMWR until the memory port reports ready.
module mc_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memreq,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       branch,
    output logic       pcwrite,
    output logic       pcen,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_memreq, w_memwrite, w_irwrite, w_regwrite, w_branch, w_pcwrite;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_memreq   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_branch   = 1'b0;
        w_pcwrite  = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_memreq  = 1'b1;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                alusrcb   = 2'b01;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_memreq = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
            end
            S_MEMWR: begin
                w_memreq   = 1'b1;
                w_memwrite = 1'b1;
                iord       = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  w_regwrite = 1'b1;
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are forced low while reset is held; the state is already FETCH, so selects match it.
    assign memreq   = w_memreq & reset_n;
    assign memwrite = w_memwrite & reset_n;
    assign irwrite  = w_irwrite & reset_n;
    assign regwrite = w_regwrite & reset_n;
    assign branch   = w_branch & reset_n;
    assign pcwrite  = w_pcwrite & reset_n;
    assign pcen     = pcwrite | (branch & zero);
    assign state    = r_state;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: random instruction streams with random memory stalls, checked cycle by cycle
// against an instruction-level model of the control sequence.
module tb_mc_controller;
    logic       clk = 1'b0, reset_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] op = 6'd0;
    logic       memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       branch, pcwrite, pcen;
    logic [3:0] state;
    int         n_checks = 0, n_fail = 0;
    logic [16:0] tbl [12];

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .memreq(memreq), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .branch(branch),
        .pcwrite(pcwrite), .pcen(pcen), .state(state)
    );

    wire [16:0] obs = {memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                       alusrcb, aluop, pcsrc, branch, pcwrite, pcen};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected output word: per-state table, FETCH enables gated by mem_ready, pcen derived.
    function automatic logic [16:0] exp_out(input int st, input bit mr, input bit z);
        logic [16:0] v;
        v = tbl[st];
        if (st == 0 && mr) begin
            v[13] = 1'b1;
            v[1]  = 1'b1;
        end
        v[0] = v[1] | (v[2] & z);
        return v;
    endfunction

    task automatic do_cycle(input int st, input bit mr, input bit z, input logic [5:0] opv, input string tag);
        mem_ready = mr;
        zero      = z;
        op        = opv;
        #1;
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_outs"}, 32'(obs), 32'(exp_out(st, mr, z)));
        @(posedge clk);
        #1;
    endtask

    function automatic void build_seq(input logic [5:0] opv, output int seq[$]);
        seq = {0, 1};
        case (opv)
            6'b100011: seq = {seq, 2, 3, 4};
            6'b101011: seq = {seq, 2, 5};
            6'b000000: seq = {seq, 6, 7};
            6'b000100: seq = {seq, 8};
            6'b001000: seq = {seq, 9, 10};
            6'b000010: seq = {seq, 11};
            default: ;
        endcase
    endfunction

    task automatic run_instr(input logic [5:0] opv, input bit z, input int fwait, input int mwait, input string tag);
        int seq[$];
        int w;
        build_seq(opv, seq);
        foreach (seq[i]) begin
            if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
                w = (seq[i] == 0) ? fwait : mwait;
                for (int k = 0; k < w; k++)
                    do_cycle(seq[i], 1'b0, z, (seq[i] == 0) ? 6'($urandom) : opv, tag);
                do_cycle(seq[i], 1'b1, z, (seq[i] == 0) ? 6'($urandom) : opv, tag);
            end else
                do_cycle(seq[i], 1'($urandom), z, opv, tag);
        end
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] o;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111, 6'b011111};
        tbl[0]  = 17'b1_0_0_0_0_0_0_0_01_00_00_0_0_0;
        tbl[1]  = 17'b0_0_0_0_0_0_0_0_11_00_00_0_0_0;
        tbl[2]  = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
        tbl[3]  = 17'b1_1_0_0_0_0_0_0_00_00_00_0_0_0;
        tbl[4]  = 17'b0_0_0_0_0_1_1_0_00_00_00_0_0_0;
        tbl[5]  = 17'b1_1_1_0_0_0_0_0_00_00_00_0_0_0;
        tbl[6]  = 17'b0_0_0_0_0_0_0_1_00_10_00_0_0_0;
        tbl[7]  = 17'b0_0_0_0_1_0_1_0_00_00_00_0_0_0;
        tbl[8]  = 17'b0_0_0_0_0_0_0_1_00_01_01_1_0_0;
        tbl[9]  = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
        tbl[10] = 17'b0_0_0_0_0_0_1_0_00_00_00_0_0_0;
        tbl[11] = 17'b0_0_0_0_0_0_0_0_00_00_10_0_1_1;

        mem_ready = 1'b1;
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_enables", 32'({memreq, memwrite, irwrite, regwrite, pcwrite, branch, pcen}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(6'b100011, 1'b0, 0, 0, "lw");
        run_instr(6'b101011, 1'b0, 0, 3, "sw_stall");
        run_instr(6'b000100, 1'b1, 0, 0, "beq_taken");
        run_instr(6'b000100, 1'b0, 0, 0, "beq_not");
        run_instr(6'b000000, 1'b1, 0, 0, "rtype");
        run_instr(6'b001000, 1'b0, 0, 0, "addi");
        run_instr(6'b000010, 1'b0, 0, 0, "j");
        run_instr(6'b111111, 1'b1, 2, 0, "undef");

        // Abort a store mid-MEMWR with an asynchronous reset.
        do_cycle(0, 1'b1, 1'b0, 6'b101011, "abort");
        do_cycle(1, 1'b0, 1'b0, 6'b101011, "abort");
        do_cycle(2, 1'b0, 1'b0, 6'b101011, "abort");
        mem_ready = 1'b0;
        #1;
        check("abort_memwr", 32'({state, memwrite}), 32'({4'd5, 1'b1}));
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_enables", 32'({memreq, memwrite, irwrite, regwrite, pcwrite, branch, pcen}), 32'd0);
        @(posedge clk);
        #1;
        check("abort_hold", 32'({state, memwrite, regwrite, pcen}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(6'b100011, 1'b1, 0, 1, "after_rst");

        repeat (300) begin
            o = ops[$urandom_range(0, 7)];
            run_instr(o, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
